// File: rtl/twiddle_pkg.sv
// Shared constants, enums and the ROM initialisation function for the
// runtime-configurable twiddle-factor sequencer.
package twiddle_pkg;

    localparam int unsigned TW_W = 18;              // twiddle word width
    localparam int unsigned FRAC = 10;              // fractional bits, 1.0 = 1024
    localparam int unsigned L    = 1200;            // master circle size
    localparam int unsigned Q    = L / 4;           // quarter-wave length
    localparam int unsigned NW   = 11;              // n1/n2 loop count width
    localparam int unsigned PW   = $clog2(L);       // phase width
    localparam int unsigned AW   = $clog2(Q + 1);   // ROM address width

    // Fixed-point scale 2^30 used only while building the ROM table
    localparam longint ONE_FX = 64'sd1073741824;
    localparam longint PI_FX  = 64'sd3373259426;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quad_e;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    // round(2^frac * cos(2*pi*i/l)) for 0 <= i <= l/4, integer Taylor series
    function automatic int cos_q(input int i, input int l = int'(L),
                                 input int frac = int'(FRAC));
        longint x;
        longint x2;
        longint term;
        longint sum;
        x    = (longint'(2) * PI_FX * longint'(i)) / longint'(l);
        x2   = (x * x) >>> 30;
        term = ONE_FX;
        sum  = ONE_FX;
        for (int k = 1; k <= 12; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k - 1) * (2 * k));
            sum  = sum + term;
        end
        return int'((sum + (ONE_FX >>> (frac + 1))) >>> (30 - frac));
    endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Quarter-wave cosine ROM with two registered read ports.
// Ports: clk, rst (sync, active high), en (read enable / hold),
//        addr_a/addr_b (0..L/4), data_a/data_b (C[addr], sign-extended).
module twiddle_qrom
    import twiddle_pkg::*;
#(
    parameter int unsigned ROM_L    = L,
    parameter int unsigned ROM_FRAC = FRAC,
    parameter int unsigned ROM_W    = TW_W,
    parameter int unsigned ROM_AW   = $clog2(ROM_L / 4 + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ROM_AW-1:0] addr_a,
    input  logic [ROM_AW-1:0] addr_b,
    output logic [ROM_W-1:0]  data_a,
    output logic [ROM_W-1:0]  data_b
);

    localparam int unsigned RQ = ROM_L / 4;

    logic [ROM_W-1:0] rom [0:RQ];
    logic [ROM_W-1:0] data_a_q, data_a_d;
    logic [ROM_W-1:0] data_b_q, data_b_d;

    // Table contents are fixed at elaboration
    for (genvar g = 0; g <= RQ; g++) begin : g_rom
        assign rom[g] = ROM_W'(cos_q(g, int'(ROM_L), int'(ROM_FRAC)));
    end

    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (en) begin
            data_a_d = rom[addr_a];
            data_b_d = rom[addr_b];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
        end
    end

    assign data_a = data_a_q;
    assign data_b = data_b_q;

endmodule

// File: rtl/twiddle_gen.sv
// Twiddle-factor sequencer: streams W_N^(n*k), k outer / n inner, N = L/scale.
// Ports: clk, rst (sync, active high), start/n1/n2/scale/inv (request),
//        busy, out_valid/out_ready/tw_re/tw_im/out_last (output stream).
module twiddle_gen
    import twiddle_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NW-1:0]   n1,
    input  logic [NW-1:0]   n2,
    input  logic [PW-1:0]   scale,
    input  logic            inv,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TW_W-1:0] tw_re,
    output logic [TW_W-1:0] tw_im,
    output logic            out_last
);

    localparam int unsigned PW1 = PW + 1;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic [NW-1:0]   n1_q, n1_d, n2_q, n2_d, n_q, n_d, k_q, k_d;
    logic [PW-1:0]   scale_q, scale_d, step_q, step_d, p_q, p_d;
    logic            inv_q, inv_d;
    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    quad_e           s2_quad_q, s2_quad_d;
    logic [AW-1:0]   s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic            s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
    quad_e           s3_quad_q, s3_quad_d;
    logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [TW_W-1:0] tw_re_q, tw_re_d, tw_im_q, tw_im_d;

    logic            adv;
    logic            s1_last;
    logic            n_wrap;
    logic [PW1-1:0]  p_sum, step_sum;
    logic [PW-1:0]   p_next, step_next, r;
    quad_e           quad;
    logic [TW_W-1:0] rom_a, rom_b, c_v, s_v;

    twiddle_qrom #(
        .ROM_L    (L),
        .ROM_FRAC (FRAC),
        .ROM_W    (TW_W),
        .ROM_AW   (AW)
    ) u_qrom (
        .clk    (clk),
        .rst    (rst),
        .en     (adv),
        .addr_a (s2_a_q),
        .addr_b (s2_b_q),
        .data_a (rom_a),
        .data_b (rom_b)
    );

    always_comb begin
        state_d     = state_q;
        n1_d        = n1_q;
        n2_d        = n2_q;
        scale_d     = scale_q;
        inv_d       = inv_q;
        n_d         = n_q;
        k_d         = k_q;
        step_d      = step_q;
        p_d         = p_q;
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        s2_last_d   = s2_last_q;
        s2_quad_d   = s2_quad_q;
        s2_a_d      = s2_a_q;
        s2_b_d      = s2_b_q;
        s3_valid_d  = s3_valid_q;
        s3_last_d   = s3_last_q;
        s3_quad_d   = s3_quad_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        tw_re_d     = tw_re_q;
        tw_im_d     = tw_im_q;

        // Whole pipeline stalls only while a presented sample is refused
        adv     = ~out_valid_q | out_ready;
        n_wrap  = (n_q == n1_q - NW'(1));
        s1_last = n_wrap && (k_q == n2_q - NW'(1));

        // Both operands are < L, so one conditional subtract wraps them
        p_sum     = {1'b0, p_q} + {1'b0, step_q};
        p_next    = (p_sum >= PW1'(L)) ? PW'(p_sum - PW1'(L)) : PW'(p_sum);
        step_sum  = {1'b0, step_q} + {1'b0, scale_q};
        step_next = (step_sum >= PW1'(L)) ? PW'(step_sum - PW1'(L)) : PW'(step_sum);

        // Quadrant fold by comparison against Q, 2Q, 3Q
        if (p_q < PW'(Q)) begin
            quad = Q0;
            r    = p_q;
        end else if (p_q < PW'(2 * Q)) begin
            quad = Q1;
            r    = p_q - PW'(Q);
        end else if (p_q < PW'(3 * Q)) begin
            quad = Q2;
            r    = p_q - PW'(2 * Q);
        end else begin
            quad = Q3;
            r    = p_q - PW'(3 * Q);
        end

        // Rebuild cos/sin from the quarter-wave samples
        case (s3_quad_q)
            Q0: begin c_v = rom_a;  s_v = rom_b;  end
            Q1: begin c_v = -rom_b; s_v = rom_a;  end
            Q2: begin c_v = -rom_a; s_v = -rom_b; end
            default: begin c_v = rom_b; s_v = -rom_a; end
        endcase

        // Sequence control and index/phase accumulation
        case (state_q)
            IDLE: begin
                if (start && (n1 != '0) && (n2 != '0)) begin
                    state_d    = RUN;
                    n1_d       = n1;
                    n2_d       = n2;
                    scale_d    = scale;
                    inv_d      = inv;
                    n_d        = '0;
                    k_d        = '0;
                    step_d     = '0;
                    p_d        = '0;
                    s1_valid_d = 1'b1;
                end
            end
            RUN: begin
                if (adv) begin
                    if (s1_last) begin
                        s1_valid_d = 1'b0;
                        state_d    = DRAIN;
                    end else if (n_wrap) begin
                        n_d    = '0;
                        k_d    = k_q + NW'(1);
                        step_d = step_next;
                        p_d    = '0;
                    end else begin
                        n_d = n_q + NW'(1);
                        p_d = p_next;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pipeline stages 2..4 advance together
        if (adv) begin
            s2_valid_d  = s1_valid_q;
            s2_last_d   = s1_valid_q & s1_last;
            s2_quad_d   = quad;
            s2_a_d      = AW'(r);
            s2_b_d      = AW'(Q) - AW'(r);
            s3_valid_d  = s2_valid_q;
            s3_last_d   = s2_last_q;
            s3_quad_d   = s2_quad_q;
            out_valid_d = s3_valid_q;
            out_last_d  = s3_valid_q & s3_last_q;
            if (s3_valid_q) begin
                tw_re_d = c_v;
                tw_im_d = inv_q ? s_v : -s_v;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            n1_q        <= '0;
            n2_q        <= '0;
            scale_q     <= '0;
            inv_q       <= 1'b0;
            n_q         <= '0;
            k_q         <= '0;
            step_q      <= '0;
            p_q         <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_quad_q   <= Q0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s3_valid_q  <= 1'b0;
            s3_last_q   <= 1'b0;
            s3_quad_q   <= Q0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            tw_re_q     <= '0;
            tw_im_q     <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            n1_q        <= n1_d;
            n2_q        <= n2_d;
            scale_q     <= scale_d;
            inv_q       <= inv_d;
            n_q         <= n_d;
            k_q         <= k_d;
            step_q      <= step_d;
            p_q         <= p_d;
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_quad_q   <= s2_quad_d;
            s2_a_q      <= s2_a_d;
            s2_b_q      <= s2_b_d;
            s3_valid_q  <= s3_valid_d;
            s3_last_q   <= s3_last_d;
            s3_quad_q   <= s3_quad_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            tw_re_q     <= tw_re_d;
            tw_im_q     <= tw_im_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign tw_re     = tw_re_q;
    assign tw_im     = tw_im_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: stimulus pushes expected samples,
// a negedge monitor pops and compares every accepted output sample.
module tb_twiddle_gen;

    localparam int TW_W = 18;
    localparam int NW   = 11;
    localparam int PW   = 11;
    localparam int LL   = 1200;
    localparam real PI  = 3.14159265358979323846;

    typedef struct {
        int re;
        int im;
        int last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NW-1:0]   n1, n2;
    logic [PW-1:0]   scale;
    logic            inv;
    logic            busy, out_valid, out_ready, out_last;
    logic [TW_W-1:0] tw_re, tw_im;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rx_count = 0;

    int n12_re [14] = '{1024, 1024, 1024, 1024, 1024, 1024, 1024,
                        1024, 887, 512, 0, -512, -887, -1024};
    int n12_im [14] = '{0, 0, 0, 0, 0, 0, 0,
                        0, -512, -887, -1024, -887, -512, 0};

    twiddle_gen dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n1        (n1),
        .n2        (n2),
        .scale     (scale),
        .inv       (inv),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tw_re     (tw_re),
        .tw_im     (tw_im),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    task automatic push(input int re, input int im, input int last);
        exp_t e;
        e.re = re;
        e.im = im;
        e.last = last;
        sb.push_back(e);
    endtask

    // Golden twiddles straight from the unit circle
    task automatic push_golden(input int gn1, input int gn2, input int gsc, input int ginv);
        int  m;
        real th;
        int  re;
        int  im;
        for (int k = 0; k < gn2; k++) begin
            for (int n = 0; n < gn1; n++) begin
                m  = (n * k * gsc) % LL;
                th = 2.0 * PI * real'(m) / real'(LL);
                re = rnd(1024.0 * $cos(th));
                im = rnd(1024.0 * $sin(th));
                if (ginv == 0) im = -im;
                push(re, im, (k == gn2 - 1 && n == gn1 - 1) ? 1 : 0);
            end
        end
    endtask

    task automatic push_n12(input int pinv);
        for (int i = 0; i < 14; i++) begin
            push(n12_re[i], (pinv != 0) ? -n12_im[i] : n12_im[i], (i == 13) ? 1 : 0);
        end
    endtask

    task automatic do_start(input int a1, input int a2, input int sc, input int iv);
        start = 1'b1;
        n1    = NW'(a1);
        n2    = NW'(a2);
        scale = PW'(sc);
        inv   = iv[0];
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget, input bit rnd_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (!busy && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=busy%0d/pending%0d expected=idle/0", nm, busy, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare accepted samples, verify outputs hold during stalls
    bit              prev_stall = 1'b0;
    logic [TW_W-1:0] prev_re, prev_im;
    logic            prev_last;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_re", int'($signed(tw_re)), int'($signed(prev_re)));
                chk("stall_im", int'($signed(tw_im)), int'($signed(prev_im)));
                chk("stall_last", int'(out_last), int'(prev_last));
            end
            if (out_valid && out_ready) begin
                rx_count++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_sample actual=(%0d,%0d) expected=none",
                             $signed(tw_re), $signed(tw_im));
                end else begin
                    e = sb.pop_front();
                    chk("tw_re", int'($signed(tw_re)), e.re);
                    chk("tw_im", int'($signed(tw_im)), e.im);
                    chk("out_last", int'(out_last), e.last);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = tw_re;
            prev_im    = tw_im;
            prev_last  = out_last;
        end
    end

    initial begin
        int rx0;
        rst = 1'b1; start = 1'b0; n1 = '0; n2 = '0; scale = '0; inv = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last", int'(out_last), 0);
        chk("rst_re", int'(tw_re), 0);
        chk("rst_im", int'(tw_im), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // N=75, 2x2, with first-sample latency
        push(1024, 0, 0); push(1024, 0, 0); push(1024, 0, 0); push(1020, -86, 1);
        do_start(2, 2, 16, 0);
        chk("busy_after_accept", int'(busy), 1);
        chk("lat_edge0", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_edge1", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_edge2", int'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_edge3", int'(out_valid), 1);
        wait_done("n75_2x2", 100, 1'b0);
        chk("n75_valid_after", int'(out_valid), 0);

        // N=12, 7x2, forward then inverse
        push_n12(0);
        do_start(7, 2, 100, 0);
        wait_done("n12_fwd", 200, 1'b0);
        push_n12(1);
        do_start(7, 2, 100, 1);
        wait_done("n12_inv", 200, 1'b0);

        // N=75, 75x75 with random backpressure
        push_golden(75, 75, 16, 0);
        do_start(75, 75, 16, 0);
        wait_done("n75_full", 40000, 1'b1);

        // Reset mid-run aborts, then a fresh run starts from (1024,0)
        push_golden(75, 75, 16, 0);
        do_start(75, 75, 16, 0);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        rst = 1'b0;
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        push(1024, 0, 0); push(1024, 0, 0); push(1024, 0, 0); push(1020, -86, 1);
        do_start(2, 2, 16, 0);
        wait_done("after_rst", 100, 1'b0);

        // n1=0 produces nothing
        do_start(0, 5, 16, 0);
        chk("n1zero_busy", int'(busy), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("n1zero_valid", int'(out_valid), 0);
        chk("n1zero_busy_later", int'(busy), 0);

        // start while busy is ignored
        rx0 = rx_count;
        push_n12(0);
        do_start(7, 2, 100, 0);
        repeat (3) @(posedge clk);
        #1;
        do_start(2, 2, 16, 0);
        wait_done("busy_start", 200, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("busy_start_count", rx_count - rx0, 14);

        // Single-sample sequence
        push(1024, 0, 1);
        do_start(1, 1, 16, 0);
        chk("single_busy", int'(busy), 1);
        wait_done("single", 50, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
